// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - control/fetch bundle between decode, sequencer and instruction memory
//
// Purpose: groups the decode-side control strobes and the fetch-side outputs
//          of pc_sequencer into one interface.
// Signals:
//   start, stall, halt, branch, branch_conditional, zero, call, ret, target[6:0]
//     - driven by the decode/control unit (master)
//   PC[6:0], fetch_valid, done, stack_err
//     - driven by the sequencer (slave)
interface pc_sequencer_if;
  logic       start;
  logic       stall;
  logic       halt;
  logic       branch;
  logic       branch_conditional;
  logic       zero;
  logic       call;
  logic       ret;
  logic [6:0] target;
  logic [6:0] PC;
  logic       fetch_valid;
  logic       done;
  logic       stack_err;

  modport master (
    output start, stall, halt, branch, branch_conditional, zero, call, ret, target,
    input  PC, fetch_valid, done, stack_err
  );

  modport slave (
    input  start, stall, halt, branch, branch_conditional, zero, call, ret, target,
    output PC, fetch_valid, done, stack_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - 7-bit program counter sequencer with bounded hardware return stack
//
// Purpose: owns the fetch PC, sequences IDLE/RUN/DONE, handles stall, halt,
//          branches and call/return through a STACK_DEPTH-entry return stack.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-low reset
//   bus        - pc_sequencer_if.slave (control in, PC/fetch_valid/done/stack_err out)
//   run_cycles - [15:0] saturating count of cycles spent in RUN
//                (present only when PC_SEQ_CYCLE_COUNT_EN is defined)
// Parameters:
//   START_PC    - PC loaded on reset and on every start
//   STACK_DEPTH - number of return-address entries (1..8)
module pc_sequencer #(
  parameter logic [6:0] START_PC    = 7'd0,
  parameter int         STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  pc_sequencer_if.slave     bus
`ifdef PC_SEQ_CYCLE_COUNT_EN
  ,
  output logic [15:0]       run_cycles
`endif
);

  localparam int SP_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      pc_q, pc_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic            err_q, err_d;
  logic [6:0]      stack_q [STACK_DEPTH];
  logic [6:0]      stack_d [STACK_DEPTH];

  logic            taken;
  logic [6:0]      pop_addr;
  logic [6:0]      pc_inc;

  assign taken  = bus.branch && (!bus.branch_conditional || bus.zero);
  // Modulo-128 wrap falls out of the 7-bit add.
  assign pc_inc = pc_q + 7'd1;

  // Top-of-stack read: entry sp-1, selected by compare so sp never needs slicing.
  always_comb begin
    pop_addr = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (sp_q == SP_W'(i + 1)) pop_addr = stack_q[i];
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    stack_d = stack_q;

    unique case (state_q)
      IDLE: begin
        pc_d = START_PC;
        if (bus.start) begin
          state_d = RUN;
          sp_d    = '0;
        end
      end

      RUN: begin
        if (bus.start) begin
          pc_d = START_PC;
          sp_d = '0;
        end else if (!bus.stall) begin
          if (bus.halt) begin
            state_d = DONE;
          end else if (bus.ret) begin
            if (sp_q != '0) begin
              pc_d = pop_addr;
              sp_d = sp_q - SP_W'(1);
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end else if (bus.call) begin
            if (sp_q < SP_W'(STACK_DEPTH)) begin
              for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_q == SP_W'(i)) stack_d[i] = pc_inc;
              end
              sp_d = sp_q + SP_W'(1);
              pc_d = bus.target;
            end else begin
              err_d   = 1'b1;
              state_d = DONE;
            end
          end else if (taken) begin
            pc_d = bus.target;
          end else begin
            pc_d = pc_inc;
          end
        end
      end

      DONE: begin
        if (bus.start) begin
          pc_d    = START_PC;
          sp_d    = '0;
          err_d   = 1'b0;
          state_d = RUN;
        end
      end

      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
        sp_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Stack contents are don't-care after reset; sp alone defines validity.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.PC          = pc_q;
  assign bus.fetch_valid = (state_q == RUN);
  assign bus.done        = (state_q == DONE);
  assign bus.stack_err   = err_q;

`ifdef PC_SEQ_CYCLE_COUNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (bus.start) begin
      cyc_d = '0;
    end else if (state_q == RUN && cyc_q != 16'hFFFF) begin
      cyc_d = cyc_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_q <= '0;
    else        cyc_q <= cyc_d;
  end

  assign run_cycles = cyc_q;
`endif

endmodule
